// File: rtl/reg_file_mp_pkg.sv
// reg_file_mp_pkg: shared constants and types for the multi-port register file.
//   DATA_W_DEF / ADDR_W_DEF : default data and address widths
//   ZERO_ADDR               : address of the hard-wired zero register
//   state_e                 : clear/run sequencer states
package reg_file_mp_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 5;
   localparam int ZERO_ADDR  = 0;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_e;

endpackage

// File: rtl/reg_file_rd_mux.sv
// reg_file_rd_mux: one combinational read port of reg_file_mp.
//   en_i          : block is ready; when low the port reads zero
//   ra_i          : read address
//   arr_i         : stored array value at ra_i (pre-edge contents)
//   we0_i/wa0_i/wd0_i : accepted write, port 0 (ALU)
//   we1_i/wa1_i/wd1_i : accepted write, port 1 (load, higher priority)
//   rd_o          : read data
module reg_file_rd_mux
   import reg_file_mp_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              en_i,
   input  logic [ADDR_W-1:0] ra_i,
   input  logic [DATA_W-1:0] arr_i,
   input  logic              we0_i,
   input  logic [ADDR_W-1:0] wa0_i,
   input  logic [DATA_W-1:0] wd0_i,
   input  logic              we1_i,
   input  logic [ADDR_W-1:0] wa1_i,
   input  logic [DATA_W-1:0] wd1_i,
   output logic [DATA_W-1:0] rd_o
);

   logic zero_hit;
   logic byp_hit1;
   logic byp_hit0;

   always_comb begin
      zero_hit = (ZERO_REG != 0) && (ra_i == ADDR_W'(ZERO_ADDR));
      byp_hit1 = (BYPASS != 0) && we1_i && (wa1_i == ra_i);
      byp_hit0 = (BYPASS != 0) && we0_i && (wa0_i == ra_i);
   end

   // Zero register beats bypass; load-port bypass beats ALU-port bypass.
   always_comb begin
      rd_o = arr_i;
      if (!en_i) begin
         rd_o = '0;
      end else if (zero_hit) begin
         rd_o = '0;
      end else if (byp_hit1) begin
         rd_o = wd1_i;
      end else if (byp_hit0) begin
         rd_o = wd0_i;
      end
   end

endmodule

// File: rtl/reg_file_mp.sv
// reg_file_mp: decode-stage register file, two write ports, NUM_RD read ports.
//   clk, rst      : clock, synchronous active-high reset
//   ra / rd       : packed read addresses / read data, port i at [i*W +: W]
//   we0/wa0/wd0   : write port 0 (ALU writeback)
//   we1/wa1/wd1   : write port 1 (load writeback, wins on address conflict)
//   ready         : high once every entry has been cleared after reset
module reg_file_mp
   import reg_file_mp_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_RD*ADDR_W-1:0] ra,
   output logic [NUM_RD*DATA_W-1:0] rd,
   input  logic                     we0,
   input  logic [ADDR_W-1:0]        wa0,
   input  logic [DATA_W-1:0]        wd0,
   input  logic                     we1,
   input  logic [ADDR_W-1:0]        wa1,
   input  logic [DATA_W-1:0]        wd1,
   output logic                     ready
);

   localparam int DEPTH = 1 << ADDR_W;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic              ready_q, ready_d;

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic run;
   logic clr_en;
   logic wr0_en;
   logic wr1_en;

   // ---------------- clear sequencer ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_CLEAR;
         clr_cnt_q <= '0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         ready_q   <= ready_d;
      end
   end

   // ready trails the CLEAR->RUN transition by one cycle.
   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      ready_d   = ready_q;
      unique case (state_q)
         ST_CLEAR: begin
            ready_d   = 1'b0;
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == '1) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            ready_d = 1'b1;
         end
         default: begin
            state_d   = ST_CLEAR;
            clr_cnt_d = '0;
            ready_d   = 1'b0;
         end
      endcase
   end

   // ---------------- write arbitration ----------------
   always_comb begin
      run    = (state_q == ST_RUN);
      clr_en = (state_q == ST_CLEAR);
      wr1_en = run && we1 &&
               !((ZERO_REG != 0) && (wa1 == ADDR_W'(ZERO_ADDR)));
      wr0_en = run && we0 &&
               !((ZERO_REG != 0) && (wa0 == ADDR_W'(ZERO_ADDR))) &&
               !(we1 && (wa1 == wa0));
   end

   // Array has no reset; the sequencer clears it one entry per cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (clr_en) begin
            mem_q[clr_cnt_q] <= '0;
         end
         if (wr0_en) begin
            mem_q[wa0] <= wd0;
         end
         if (wr1_en) begin
            mem_q[wa1] <= wd1;
         end
      end
   end

   // ---------------- read ports ----------------
   for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
      logic [ADDR_W-1:0] ra_g;
      logic [DATA_W-1:0] rd_g;

      assign ra_g = ra[g*ADDR_W +: ADDR_W];
      assign rd[g*DATA_W +: DATA_W] = rd_g;

      reg_file_rd_mux #(
         .DATA_W   (DATA_W),
         .ADDR_W   (ADDR_W),
         .ZERO_REG (ZERO_REG),
         .BYPASS   (BYPASS)
      ) u_rd_mux (
         .en_i  (ready_q),
         .ra_i  (ra_g),
         .arr_i (mem_q[ra_g]),
         .we0_i (wr0_en),
         .wa0_i (wa0),
         .wd0_i (wd0),
         .we1_i (wr1_en),
         .wa1_i (wa1),
         .wd1_i (wd1),
         .rd_o  (rd_g)
      );
   end

   assign ready = ready_q;

endmodule
